// File: rtl/demux_scan_ctrl.sv
// demux_scan_ctrl: drives a 1:4 demux select/data, routing one channel or scanning 0..3
// with a fixed dwell per channel and a guard gap so select never moves while data is high.
module demux_scan_ctrl #(
    parameter int DWELL = 4,
    parameter int GAP   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mode,
    input  logic [1:0] ch,
    output logic [1:0] s,
    output logic       i,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_GAP, ST_DONE} state_t;
    localparam logic [7:0] DW_LD = 8'(DWELL - 1);
    localparam logic [7:0] GP_LD = 8'(GAP - 1);
    state_t     r_state, w_next;
    logic [7:0] r_cnt, w_cnt;
    logic [1:0] r_cur, r_last, w_cur, w_last;
    logic       r_i, r_busy, r_done;
    logic       w_i, w_busy, w_done, w_accept, w_cnt_end;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
            r_cur   <= 2'd0;
            r_last  <= 2'd0;
            r_i     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt;
            r_cur   <= w_cur;
            r_last  <= w_last;
            r_i     <= w_i;
            r_busy  <= w_busy;
            r_done  <= w_done;
        end
    end
    always_comb begin
        w_accept  = (r_state == ST_IDLE) && start;
        w_cnt_end = (r_cnt == 8'd0);
        w_next    = w_accept ? ST_DRIVE
                  : (r_state == ST_DRIVE && w_cnt_end) ? ((r_cur == r_last) ? ST_DONE : ST_GAP)
                  : (r_state == ST_GAP && w_cnt_end) ? ST_DRIVE
                  : (r_state == ST_DONE) ? ST_IDLE
                  : r_state;
    end
    // Select only advances on the gap->drive edge, while i is still low.
    always_comb begin
        w_cur  = w_accept ? (mode ? 2'd0 : ch)
               : (r_state == ST_GAP && w_cnt_end) ? r_cur + 2'd1
               : r_cur;
        w_last = w_accept ? (mode ? 2'd3 : ch) : r_last;
        w_cnt  = (w_next == r_state) ? r_cnt - {7'd0, !w_cnt_end}
               : (w_next == ST_GAP) ? GP_LD : DW_LD;
        w_i    = (w_next == ST_DRIVE);
        w_busy = (w_next == ST_DRIVE) || (w_next == ST_GAP);
        w_done = (w_next == ST_DONE);
    end
    assign s    = r_cur;
    assign i    = r_i;
    assign busy = r_busy;
    assign done = r_done;
endmodule

// File: tb/tb_demux_scan_ctrl.sv
// tb_demux_scan_ctrl: per-op expected traces from a channel-list model feed a scoreboard
// that a negedge monitor drains, plus a select-stability check while i stays high.
module tb_demux_scan_ctrl;
    localparam int DW = 4;
    localparam int GP = 1;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b1;
    logic       mode = 1'b0;
    logic [1:0] ch = 2'd0;
    logic [1:0] s;
    logic       i, busy, done;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [4:0] exp_q[$];
    logic [4:0] plan[$];

    always #5 clk = ~clk;

    demux_scan_ctrl #(.DWELL(DW), .GAP(GP)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .ch(ch),
        .s(s), .i(i), .busy(busy), .done(done)
    );

    // Entries are {s, i, busy, done}; an op is its channel list expanded into cycles.
    function automatic void build(input logic md, input logic [1:0] c);
        int first = md ? 0 : int'(c);
        int last  = md ? 3 : int'(c);
        for (int k = first; k <= last; k++) begin
            for (int d = 0; d < DW; d++) plan.push_back({2'(k), 3'b110});
            if (k != last) for (int g = 0; g < GP; g++) plan.push_back({2'(k), 3'b010});
        end
        plan.push_back({2'(last), 3'b001});
        plan.push_back({2'(last), 3'b000});
    endfunction

    initial begin
        logic [4:0] e;
        logic [1:0] m_s;
        m_s = 2'd0;
        forever begin
            @(posedge clk);
            if (rst) begin
                plan.delete();
                m_s = 2'd0;
                e = 5'd0;
            end else begin
                if (plan.size() == 0 && start) build(mode, ch);
                e = (plan.size() == 0) ? {m_s, 3'b000} : plan.pop_front();
                m_s = e[4:3];
            end
            exp_q.push_back(e);
        end
    end

    initial begin
        logic [4:0] e;
        logic [1:0] ps;
        logic       pi;
        ps = 2'd0;
        pi = 1'b0;
        forever begin
            @(negedge clk);
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL underflow: DUT output s=%0d i=%b with no expected entry", s, i);
            end else begin
                e = exp_q.pop_front();
                if ({s, i, busy, done} !== e) begin
                    n_bad++;
                    $display("FAIL out @%0t: got s=%0d i=%b busy=%b done=%b, want s=%0d i=%b busy=%b done=%b",
                             $time, s, i, busy, done, e[4:3], e[2], e[1], e[0]);
                end
            end
            if (pi && i === 1'b1) begin
                n_cmp++;
                if (s !== ps) begin
                    n_bad++;
                    $display("FAIL glitch @%0t: s moved %0d->%0d while i high", $time, ps, s);
                end
            end
            ps = s;
            pi = i;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        cyc(2);
        rst = 1'b0; start = 1'b0;
        cyc(3);
        mode = 1'b0; ch = 2'd2; start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(8);
        mode = 1'b1; start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(22);
        mode = 1'b1; start = 1'b1;
        cyc(1);
        mode = 1'b0; ch = 2'd1;
        cyc(1);
        start = 1'b0;
        repeat (10) begin
            ch = ch + 2'd1;
            cyc(1);
        end
        cyc(12);
        mode = 1'b1; start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(5);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0; mode = 1'b0; ch = 2'd3; start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(8);
        mode = 1'b0; ch = 2'd3; start = 1'b1;
        cyc(20);
        start = 1'b0;
        cyc(8);
        repeat (400) begin
            rst   = ($urandom_range(0, 63) == 0);
            start = ($urandom_range(0, 3) == 0);
            mode  = 1'($urandom);
            ch    = 2'($urandom);
            cyc(1);
        end
        rst = 1'b0; start = 1'b0;
        cyc(30);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
